// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch front end: one outstanding I-cache read, one-entry hold buffer, mispredict squash.
// Define FETCH_PERF_EN to add the fetch_cnt/squash_cnt performance counter outputs.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_mispredict,
  input  logic [31:0] br_target,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] data_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] SQUASH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] data_out_q, data_out_d;
  logic        load;
  logic        slot_free;
  logic [31:0] tgt_aligned;

  assign tgt_aligned = br_target & ~32'h0000_0003;
  assign slot_free   = !valid_q || !stall_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    hold_pc_d   = hold_pc_q;
    hold_data_d = hold_data_q;
    valid_d     = valid_q;
    pc_out_d    = pc_out_q;
    data_out_d  = data_out_q;
    load        = 1'b0;

    if (br_mispredict) begin
      // Redirect beats stall and response; a live read must still finish before retargeting.
      pc_d       = tgt_aligned;
      valid_d    = 1'b0;
      data_out_d = NOP_INST;
      case (state_q)
        REQ: begin
          if (inst_resp) req_addr_d = tgt_aligned;
          else           state_d    = SQUASH;
        end
        SQUASH: begin
          if (inst_resp) begin
            req_addr_d = tgt_aligned;
            state_d    = REQ;
          end
        end
        default: begin
          req_addr_d = tgt_aligned;
          state_d    = REQ;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
        REQ: begin
          if (inst_resp) begin
            if (slot_free) begin
              load       = 1'b1;
              pc_out_d   = req_addr_q;
              data_out_d = inst_rdata;
              pc_d       = req_addr_q + 32'd4;
              req_addr_d = req_addr_q + 32'd4;
            end else begin
              hold_pc_d   = req_addr_q;
              hold_data_d = inst_rdata;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            load       = 1'b1;
            pc_out_d   = hold_pc_q;
            data_out_d = hold_data_q;
            pc_d       = hold_pc_q + 32'd4;
            req_addr_d = hold_pc_q + 32'd4;
            state_d    = REQ;
          end
        end
        default: begin
          if (inst_resp) begin
            req_addr_d = pc_q;
            state_d    = REQ;
          end
        end
      endcase

      if (load)                      valid_d = 1'b1;
      else if (valid_q && !stall_i) begin
        valid_d    = 1'b0;
        data_out_d = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      hold_pc_q   <= '0;
      hold_data_q <= NOP_INST;
      valid_q     <= 1'b0;
      pc_out_q    <= '0;
      data_out_q  <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      hold_pc_q   <= hold_pc_d;
      hold_data_q <= hold_data_d;
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign inst_read = (state_q == REQ) || (state_q == SQUASH);
  assign inst_addr = req_addr_q;
  assign valid_out = valid_q;
  assign pc_out    = pc_out_q;
  assign data_out  = data_out_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;
  logic        discard;

  // A response is thrown away when it completes a squashed read or collides with a redirect.
  assign discard = inst_resp && ((state_q == SQUASH) || ((state_q == REQ) && br_mispredict));

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, load};
    squash_cnt_d = squash_cnt_q + {31'd0, discard};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus a randomized run against
// a transaction-level model (outstanding read, live/squashed flag, pending-instruction queue).
module tb_inst_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_mispredict = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        inst_resp = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] data_out;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] squash_cnt;
`endif

  int errors = 0;
  int checks = 0;

  inst_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_mispredict(br_mispredict),
    .br_target    (br_target),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_resp    (inst_resp),
    .inst_rdata   (inst_rdata),
    .valid_out    (valid_out),
    .pc_out       (pc_out),
    .data_out     (data_out)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .squash_cnt   (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [97:0] obs();
    return {inst_read, inst_addr, valid_out, pc_out, data_out};
  endfunction

  function automatic logic [97:0] ev(input logic rd, input logic [31:0] a, input logic v,
                                     input logic [31:0] p, input logic [31:0] d);
    return {rd, a, v, p, d};
  endfunction

  // Apply one cycle of inputs; returns at the following negedge with outputs settled.
  task automatic drive(input logic r, input logic s, input logic m, input logic [31:0] t,
                       input logic rs, input logic [31:0] d);
    rst = r; stall_i = s; br_mispredict = m; br_target = t; inst_resp = rs; inst_rdata = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    logic [97:0] exp;
    do_reset();
    exp = ev(1'b0, 32'h60, 1'b0, 32'h0, NOP); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL reset_state: got %h expected %h", obs(), exp); end
`ifdef FETCH_PERF_EN
    checks++;
    if ({fetch_cnt, squash_cnt} !== 64'h0) begin
      errors++; $display("FAIL reset_counters: got %h expected 0", {fetch_cnt, squash_cnt});
    end
`endif
  endtask

  task automatic test_basic();
    logic [97:0] exp;
    logic [31:0] prev_pc;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      prev_pc = (i == 0) ? 32'h0 : 32'h60 + 32'(4 * (i - 1));
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      exp = ev(1'b1, 32'h60 + 32'(4 * i), 1'b0, prev_pc, NOP); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL basic_wait%0d: got %h expected %h", i, obs(), exp); end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0000 + 32'(i));
      exp = ev(1'b1, 32'h64 + 32'(4 * i), 1'b1, 32'h60 + 32'(4 * i), 32'hA000_0000 + 32'(i)); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL basic_deliver%0d: got %h expected %h", i, obs(), exp); end
    end
  endtask

  task automatic test_hold();
    logic [97:0] exp;
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h5C, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0000);
    exp = ev(1'b1, 32'h60, 1'b1, 32'h5C, 32'hB000_0000); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL hold_first: got %h expected %h", obs(), exp); end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hB000_0001);
    for (int i = 0; i < 4; i++) begin
      exp = ev(1'b0, 32'h60, 1'b1, 32'h5C, 32'hB000_0000); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL hold_stalled%0d: got %h expected %h", i, obs(), exp); end
      if (i < 3) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp = ev(1'b1, 32'h64, 1'b1, 32'h60, 32'hB000_0001); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL hold_release: got %h expected %h", obs(), exp); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp = ev(1'b1, 32'h64, 1'b0, 32'h60, NOP); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL hold_drain: got %h expected %h", obs(), exp); end
  endtask

  task automatic test_squash();
    logic [97:0] exp;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0000);
    drive(1'b1, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp = ev(1'b1, 32'h64, 1'b0, 32'h60, NOP); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL squash_wait%0d: got %h expected %h", i, obs(), exp); end
      if (i < 2) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
    exp = ev(1'b1, 32'h200, 1'b0, 32'h60, NOP); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL squash_done: got %h expected %h", obs(), exp); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0001);
    exp = ev(1'b1, 32'h204, 1'b1, 32'h200, 32'hC000_0001); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL squash_target: got %h expected %h", obs(), exp); end
  endtask

  task automatic test_mp_with_resp();
    logic [97:0] exp;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h1001, 1'b1, 32'hBAD1_BAD1);
    exp = ev(1'b1, 32'h1000, 1'b0, 32'h0, NOP); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL mpresp_drop: got %h expected %h", obs(), exp); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hD000_0000);
    exp = ev(1'b1, 32'h1004, 1'b1, 32'h1000, 32'hD000_0000); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL mpresp_next: got %h expected %h", obs(), exp); end
  endtask

  task automatic test_wrap();
    logic [97:0] exp;
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
    exp = ev(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL wrap_req: got %h expected %h", obs(), exp); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hE000_0000);
    exp = ev(1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hE000_0000); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL wrap_top: got %h expected %h", obs(), exp); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hE000_0001);
    exp = ev(1'b1, 32'h4, 1'b1, 32'h0, 32'hE000_0001); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL wrap_zero: got %h expected %h", obs(), exp); end
  endtask

  task automatic test_reset_mid();
    logic [97:0] exp;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hF000_0000);
    drive(1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp = ev(1'b0, 32'h60, 1'b0, 32'h0, NOP); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL rstmid_in_reset: got %h expected %h", obs(), exp); end
`ifdef FETCH_PERF_EN
    checks++;
    if ({fetch_cnt, squash_cnt} !== 64'h0) begin
      errors++; $display("FAIL rstmid_counters: got %h expected 0", {fetch_cnt, squash_cnt});
    end
`endif
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD2_BAD2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD3_BAD3);
    exp = ev(1'b1, 32'h60, 1'b0, 32'h0, NOP); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL rstmid_late_resp: got %h expected %h", obs(), exp); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hF000_0001);
    exp = ev(1'b1, 32'h64, 1'b1, 32'h60, 32'hF000_0001); checks++;
    if (obs() !== exp) begin errors++; $display("FAIL rstmid_restart: got %h expected %h", obs(), exp); end
  endtask

  task automatic test_random();
    logic        m_idle = 1'b1, m_out = 1'b0, m_live = 1'b0, m_valid = 1'b0;
    logic [31:0] m_pc = 32'h60, m_addr = 32'h60, m_pc_out = 32'h0, m_data = NOP;
    logic [31:0] m_fcnt = 32'h0, m_scnt = 32'h0;
    logic [63:0] pend[$];
    logic        r, s, mp, rs, ld;
    logic [31:0] t, d;
    logic [63:0] entry;
    logic [97:0] exp;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r  = (cyc < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      s  = 1'($urandom_range(0, 1));
      mp = ($urandom_range(0, 9) == 0);
      t  = $urandom;
      d  = $urandom;
      rs = m_out && ($urandom_range(0, 2) == 0);
      drive(r, s, mp, t, rs, d);
      ld = 1'b0;
      if (!r) begin
        m_idle = 1'b1; m_out = 1'b0; m_live = 1'b0; m_valid = 1'b0;
        m_pc = 32'h60; m_addr = 32'h60; m_pc_out = 32'h0; m_data = NOP;
        m_fcnt = 32'h0; m_scnt = 32'h0; pend.delete();
      end else if (mp) begin
        if (m_out && rs) begin m_scnt++; m_addr = {t[31:2], 2'b00}; m_live = 1'b1; end
        else if (m_out)  m_live = 1'b0;
        else begin m_out = 1'b1; m_addr = {t[31:2], 2'b00}; m_live = 1'b1; end
        m_idle = 1'b0; m_pc = {t[31:2], 2'b00}; pend.delete(); m_valid = 1'b0; m_data = NOP;
      end else begin
        if (m_idle) begin
          m_idle = 1'b0; m_out = 1'b1; m_addr = m_pc; m_live = 1'b1;
        end else if (pend.size() != 0) begin
          if (!s) begin
            entry = pend.pop_front(); ld = 1'b1;
            m_pc_out = entry[63:32]; m_data = entry[31:0];
            m_pc = entry[63:32] + 32'd4; m_addr = m_pc; m_out = 1'b1; m_live = 1'b1;
          end
        end else if (m_out && rs) begin
          if (!m_live) begin m_scnt++; m_addr = m_pc; m_live = 1'b1; end
          else if (!m_valid || !s) begin
            ld = 1'b1; m_pc_out = m_addr; m_data = d; m_addr = m_addr + 32'd4; m_pc = m_addr;
          end else begin
            pend.push_back({m_addr, d}); m_out = 1'b0;
          end
        end
        if (ld) begin m_valid = 1'b1; m_fcnt++; end
        else if (m_valid && !s) begin m_valid = 1'b0; m_data = NOP; end
      end
      exp = ev(m_out, m_addr, m_valid, m_pc_out, m_data); checks++;
      if (obs() !== exp) begin errors++; $display("FAIL random_cyc%0d: got %h expected %h", cyc, obs(), exp); end
`ifdef FETCH_PERF_EN
      checks++;
      if ({fetch_cnt, squash_cnt} !== {m_fcnt, m_scnt}) begin
        errors++; $display("FAIL random_cnt%0d: got %h expected %h", cyc, {fetch_cnt, squash_cnt}, {m_fcnt, m_scnt});
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_squash();
    test_mp_with_resp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
